// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// ============================================================================
// bcd_pkg
// Shared definitions for the BCD stopwatch controller: run-state encoding,
// BCD digit width and the largest legal digit value.
// No ports (package).
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } sw_state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// ============================================================================
// bcd_stopwatch_ctrl_if
// Command / status bundle between the user-command source and the stopwatch.
//   start_stop, clear, lap : one-cycle command pulses (master -> slave)
//   count, display          : live and (optionally frozen) BCD values
//   running, tick, overflow : run status, increment strobe, terminal flag
// Modports: master (command source / observer), slave (stopwatch).
// ============================================================================
interface bcd_stopwatch_ctrl_if #(
    parameter int DIGITS = 4
);

    logic                               start_stop;
    logic                               clear;
    logic                               lap;
    logic [bcd_pkg::BCD_W*DIGITS-1:0]   count;
    logic [bcd_pkg::BCD_W*DIGITS-1:0]   display;
    logic                               running;
    logic                               tick;
    logic                               overflow;

    modport master (
        output start_stop, clear, lap,
        input  count, display, running, tick, overflow
    );

    modport slave (
        input  start_stop, clear, lap,
        output count, display, running, tick, overflow
    );

endinterface

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// ============================================================================
// bcd_digit
// One decimal digit of the counter chain.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   en    : increment this cycle (carry-in from the lower digits)
//   clr   : synchronous clear, dominates en
//   q     : digit value, always 0..9
//   carry : en while q is 9, i.e. this digit rolls over on this edge
// ============================================================================
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    logic [BCD_W-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= (r_q == BCD_MAX) ? '0 : r_q + 4'd1;
        end
    end

    assign q     = r_q;
    assign carry = en & (r_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// ============================================================================
// bcd_stopwatch_ctrl
// Run controller for a DIGITS-wide BCD counter chain. A prescaler divides clk
// by TICK_DIV to produce the count tick; start/stop, clear and lap-hold
// commands sequence IDLE / RUN / PAUSED (/ DONE).
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : bcd_stopwatch_ctrl_if.slave
//           in : start_stop, clear, lap (one-cycle pulses)
//           out: count, display, running, tick, overflow
// Build option: define BCD_WRAP_EN to let the count wrap from all-9s to zero
// with a one-cycle overflow pulse. Left undefined, the count saturates at
// all-9s, the FSM parks in DONE and overflow stays high until clear.
// ============================================================================
module bcd_stopwatch_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10
)(
    input  logic                 clk,
    input  logic                 reset,
    bcd_stopwatch_ctrl_if.slave  bus
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam int               CNT_W    = BCD_W * DIGITS;

    sw_state_t          r_state;
    sw_state_t          w_state_nxt;
    logic [PRE_W-1:0]   r_pre;
    logic               r_freeze;
    logic [CNT_W-1:0]   r_lap_q;
    logic               r_overflow;

    logic               w_running;
    logic               w_tick;
    logic               w_all9;
    logic               w_term;
    logic               w_sat_stop;
    logic               w_inc;
    logic               w_lap_ok;
    logic [CNT_W-1:0]   w_count;
    logic [DIGITS-1:0]  w_dig_en;
    logic [DIGITS-1:0]  w_dig_carry;
    logic [DIGITS-1:0]  w_dig9;
    logic               w_unused_carry;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. clear outranks everything; a terminal tick in the
    // saturating build outranks a simultaneous start_stop, because the
    // count has nowhere left to go.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.start_stop) w_state_nxt = RUN;
                RUN: begin
                    if (w_sat_stop)          w_state_nxt = DONE;
                    else if (bus.start_stop) w_state_nxt = PAUSED;
                end
                PAUSED:  if (bus.start_stop) w_state_nxt = RUN;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_running = (r_state == RUN);
        w_tick    = w_running && (r_pre == PRE_LAST);
    end

    // Prescaler phase survives a pause so resume keeps the remaining time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
        end else if (bus.clear) begin
            r_pre <= '0;
        end else if (w_running) begin
            r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Digit chain: digit i steps only when every lower digit rolls over.
    // ------------------------------------------------------------------
    assign w_all9 = &w_dig9;
    assign w_term = w_tick & w_all9;

`ifdef BCD_WRAP_EN
    assign w_inc      = w_tick;
    assign w_sat_stop = 1'b0;
`else
    // Hold all-9s on the terminal tick instead of rolling the chain over.
    assign w_inc      = w_tick & ~w_all9;
    assign w_sat_stop = w_term;
`endif

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        if (gi == 0) begin : g_lsd
            assign w_dig_en[gi] = w_inc;
        end else begin : g_upper
            assign w_dig_en[gi] = w_dig_carry[gi-1];
        end

        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .en    (w_dig_en[gi]),
            .clr   (bus.clear),
            .q     (w_count[gi*BCD_W +: BCD_W]),
            .carry (w_dig_carry[gi])
        );

        assign w_dig9[gi] = (w_count[gi*BCD_W +: BCD_W] == BCD_MAX);
    end

    // Carry out of the top digit has no consumer; terminal detection uses
    // w_all9 so both builds share the same path.
    assign w_unused_carry = w_dig_carry[DIGITS-1];

    // ------------------------------------------------------------------
    // Lap hold. Evaluated even when start_stop arrives in the same cycle;
    // the capture takes the count value present before this edge.
    // ------------------------------------------------------------------
    assign w_lap_ok = bus.lap & ~bus.clear & ((r_state == RUN) | (r_state == PAUSED));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_freeze <= 1'b0;
        end else if (bus.clear) begin
            r_freeze <= 1'b0;
        end else if (w_lap_ok) begin
            r_freeze <= ~r_freeze;
        end
    end

    // Only visible while r_freeze is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_lap_ok && !r_freeze) begin
            r_lap_q <= w_count;
        end
    end

    // ------------------------------------------------------------------
    // Terminal-count indicator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_overflow <= 1'b0;
        end else begin
`ifdef BCD_WRAP_EN
            r_overflow <= w_term;
`else
            if (w_term) r_overflow <= 1'b1;
`endif
        end
    end

    assign bus.count    = w_count;
    assign bus.display  = r_freeze ? r_lap_q : w_count;
    assign bus.running  = w_running;
    assign bus.tick     = w_tick;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// ============================================================================
// tb_bcd_stopwatch_ctrl
// Bench for bcd_stopwatch_ctrl with DIGITS=2, TICK_DIV=3. A behavioural model
// keeps the count as a plain integer 0..99 and the prescaler as an integer
// phase; every cycle the DUT outputs are compared with it. Directed scenarios
// cover start, carry, pause/resume, lap hold, terminal count, clear and
// asynchronous reset; a randomized command stream follows.
// Honors BCD_WRAP_EN the same way the design does.
// ============================================================================
module tb_bcd_stopwatch_ctrl;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 3;
    localparam int MAXV     = 99;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bcd_stopwatch_ctrl_if #(.DIGITS(DIGITS)) sw_if();

    bcd_stopwatch_ctrl #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sw_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int tick_seen = 0;

    // Reference model: mode 0 idle, 1 run, 2 paused, 3 done
    int m_mode, m_pre, m_cnt, m_lap;
    bit m_frz, m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pre = 0; m_cnt = 0; m_lap = 0; m_frz = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit ss, input bit cl, input bit lp);
        bit t;
        bit went_done;
        int nmode;
        if (cl) begin
            model_reset();
            return;
        end
        t         = (m_mode == 1) && (m_pre == TICK_DIV - 1);
        nmode     = m_mode;
        went_done = 1'b0;
        if (lp && (m_mode == 1 || m_mode == 2)) begin
            if (!m_frz) m_lap = m_cnt;
            m_frz = !m_frz;
        end
`ifdef BCD_WRAP_EN
        m_ovf = t && (m_cnt == MAXV);
        if (t) m_cnt = (m_cnt + 1) % (MAXV + 1);
`else
        if (t && m_cnt == MAXV) begin
            m_ovf = 1'b1;
            nmode = 3;
            went_done = 1'b1;
        end else if (t) begin
            m_cnt = m_cnt + 1;
        end
`endif
        if (m_mode == 1) m_pre = (m_pre + 1) % TICK_DIV;
        if (ss && !went_done) begin
            case (m_mode)
                0: nmode = 1;
                1: nmode = 2;
                2: nmode = 1;
                default: nmode = m_mode;
            endcase
        end
        m_mode = nmode;
    endtask

    task automatic compare_all(input string where);
        logic [7:0] c;
        c = sw_if.count;
        check({where, ".count"},    32'(sw_if.count),    32'(to_bcd(m_cnt)));
        check({where, ".display"},  32'(sw_if.display),  32'(m_frz ? to_bcd(m_lap) : to_bcd(m_cnt)));
        check({where, ".running"},  32'(sw_if.running),  32'(m_mode == 1));
        check({where, ".tick"},     32'(sw_if.tick),     32'((m_mode == 1) && (m_pre == TICK_DIV - 1)));
        check({where, ".overflow"}, 32'(sw_if.overflow), 32'(m_ovf));
        check({where, ".digits"},   32'((c[3:0] <= 4'd9) && (c[7:4] <= 4'd9)), 32'd1);
    endtask

    // Called just after an active edge: drive commands for one cycle,
    // advance the model, then compare after the next edge.
    task automatic step(input bit ss, input bit cl, input bit lp);
        sw_if.start_stop = ss;
        sw_if.clear      = cl;
        sw_if.lap        = lp;
        model_step(ss, cl, lp);
        @(posedge clk);
        #1;
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.lap        = 1'b0;
        if (sw_if.tick === 1'b1) tick_seen++;
        compare_all("cyc");
    endtask

    task automatic run_until_cnt(input int target, input int budget);
        int i;
        i = 0;
        while (m_cnt != target && i < budget) begin
            step(1'b0, 1'b0, 1'b0);
            i++;
        end
        check("reach_cnt", 32'(sw_if.count), 32'(to_bcd(target)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  i;
        int  held;
        int  r;
        bit  ss, cl, lp;

        reset            = 1'b0;
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.lap        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        reset = 1'b1;

        // Start, 15 run cycles -> 5 ticks, count 05
        step(1'b1, 1'b0, 1'b0);
        check("run_after_ss", 32'(sw_if.running), 32'd1);
        tick_seen = 0;
        repeat (15) step(1'b0, 1'b0, 1'b0);
        check("cnt_after_15", 32'(sw_if.count), 32'h05);
        check("ticks_in_15", 32'(tick_seen), 32'd5);

        // Carry 09 -> 10
        run_until_cnt(9, 30);
        run_until_cnt(10, 5);
        check("carry_10", 32'(sw_if.count), 32'h10);

        // Pause with the prescaler held at 1, then resume
        i = 0;
        while (m_pre != 0 && i < 5) begin
            step(1'b0, 1'b0, 1'b0);
            i++;
        end
        step(1'b1, 1'b0, 1'b0);
        check("paused", 32'(sw_if.running), 32'd0);
        held = m_cnt;
        repeat (20) step(1'b0, 1'b0, 1'b0);
        check("hold_paused", 32'(sw_if.count), 32'(to_bcd(held)));
        step(1'b1, 1'b0, 1'b0);
        check("resume_no_tick", 32'(sw_if.tick), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("resume_tick", 32'(sw_if.tick), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check("resume_cnt", 32'(sw_if.count), 32'(to_bcd(held + 1)));

        // Lap hold
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_until_cnt(12, 60);
        step(1'b0, 1'b0, 1'b1);
        check("lap_capture", 32'(sw_if.display), 32'h12);
        run_until_cnt(15, 20);
        check("lap_frozen", 32'(sw_if.display), 32'h12);
        step(1'b0, 1'b0, 1'b1);
        check("lap_release", 32'(sw_if.display), 32'h15);

        // Terminal count
        step(1'b0, 1'b1, 1'b0);
        check("clear_disp", 32'(sw_if.display), 32'h00);
        step(1'b1, 1'b0, 1'b0);
        run_until_cnt(99, 400);
        i = 0;
        while (!m_ovf && i < 5) begin
            step(1'b0, 1'b0, 1'b0);
            i++;
        end
`ifdef BCD_WRAP_EN
        check("wrap_cnt", 32'(sw_if.count), 32'h00);
        check("wrap_ovf", 32'(sw_if.overflow), 32'd1);
        check("wrap_run", 32'(sw_if.running), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check("wrap_ovf_pulse", 32'(sw_if.overflow), 32'd0);
`else
        check("sat_cnt", 32'(sw_if.count), 32'h99);
        check("sat_run", 32'(sw_if.running), 32'd0);
        check("sat_ovf", 32'(sw_if.overflow), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check("done_ign_ss", 32'(sw_if.running), 32'd0);
        check("done_cnt", 32'(sw_if.count), 32'h99);
        check("done_ovf", 32'(sw_if.overflow), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        check("done_clr_cnt", 32'(sw_if.count), 32'h00);
        check("done_clr_ovf", 32'(sw_if.overflow), 32'd0);
`endif

        // clear together with start_stop in RUN
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("clr_ss_run", 32'(sw_if.running), 32'd0);
        check("clr_ss_cnt", 32'(sw_if.count), 32'h00);

        // Random commands, frequent clears
        repeat (1500) begin
            r  = int'($urandom_range(0, 99));
            ss = (r < 6);
            cl = (r >= 97);
            lp = ($urandom_range(0, 15) == 0);
            step(ss, cl, lp);
        end
        // Random commands, long runs so the terminal count is reached
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (700) begin
            ss = ($urandom_range(0, 199) == 0);
            lp = ($urandom_range(0, 29) == 0);
            step(ss, 1'b0, lp);
        end

        // Asynchronous reset in the middle of a run
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b0, 1'b0);
        check("pre_reset_cnt", 32'(sw_if.count), 32'h02);
        reset = 1'b0;
        #2;
        check("areset_cnt",  32'(sw_if.count),    32'h00);
        check("areset_disp", 32'(sw_if.display),  32'h00);
        check("areset_run",  32'(sw_if.running),  32'd0);
        check("areset_tick", 32'(sw_if.tick),     32'd0);
        check("areset_ovf",  32'(sw_if.overflow), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        compare_all("post_reset");
        step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
